// File: rtl/fault_injection_ctrl.sv
// Purpose : fault-campaign controller driving the fault data, per-bit select and global
//           enable of an 18-bit fault injection mux on an NVDLA datapath tap.
// Latency : sel_out/fsel_out registered (valid in the first INJECT cycle); bit-flip
//           fdata_out is combinational from cdata_in.
// Backpressure: none; config writes to MASK/VALUE/DELAY/DURATION are dropped while busy.
//
// Optional feature macro: FAULT_INJ_LFSR_EN
//   Defined   -> CTRL[3] lfsr_en selects a Fibonacci LFSR (taps 18,11) as the fault
//                select pattern during INJECT, seeded from MASK at arm (0 -> 1).
//   Undefined -> CTRL[3] ignored, fsel_out = MASK during INJECT.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rst : clock, synchronous active-high reset
//   cfg_we / cfg_addr / cfg_wdata   : write-only config port
//                                     (0 CTRL, 1 MASK, 2 VALUE, 3 DELAY, 4 DURATION)
//   trig_in                         : external trigger, sampled only in WAIT_TRIG
//   cdata_in                        : clean datapath value (bit-flip source)
//   fdata_out / fsel_out / sel_out  : fault data, per-bit select, global enable to the mux
//   busy / done                     : campaign status
module fault_injection_ctrl #(
  parameter int WIDTH = 18,
  parameter int CNT_W = 32
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  input  logic             trig_in,
  input  logic [WIDTH-1:0] cdata_in,
  output logic [WIDTH-1:0] fdata_out,
  output logic [WIDTH-1:0] fsel_out,
  output logic             sel_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TRIG = 3'd1,
    S_DELAY     = 3'd2,
    S_INJECT    = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_MASK     = 3'd1;
  localparam logic [2:0] A_VALUE    = 3'd2;
  localparam logic [2:0] A_DELAY    = 3'd3;
  localparam logic [2:0] A_DURATION = 3'd4;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  mask_q;
  logic [WIDTH-1:0]  value_q;
  logic [CNT_W-1:0]  delay_q;
  logic [CNT_W-1:0]  dur_q;
  logic              mode_q;      // mode captured at the last arm
  logic              sel_q, sel_d;
  logic [WIDTH-1:0]  fsel_q, fsel_d;

  logic ctrl_wr;
  logic arm_cmd;
  logic abort_cmd;
  logic arm_take;
  logic inj_stay;

  // A CTRL write is either an arm (bit0=1) or an abort (bit0=0).
  assign ctrl_wr   = cfg_we && (cfg_addr == A_CTRL);
  assign arm_cmd   = ctrl_wr &&  cfg_wdata[0];
  assign abort_cmd = ctrl_wr && !cfg_wdata[0];
  // Arming is only honoured from an idle or finished campaign.
  assign arm_take  = arm_cmd && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign inj_stay  = (state_q == S_INJECT) && (state_d == S_INJECT);

`ifdef FAULT_INJ_LFSR_EN
  localparam int LFSR_TAP = 11;

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_nxt;
  logic             lfsr_en_q;

  assign lfsr_nxt = {lfsr_q[WIDTH-2:0], lfsr_q[WIDTH-1] ^ lfsr_q[LFSR_TAP-1]};

  // lfsr_q always holds the pattern currently presented on fsel_out during INJECT.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      lfsr_q    <= '0;
      lfsr_en_q <= 1'b0;
    end else if (arm_take) begin
      lfsr_q    <= (mask_q == '0) ? WIDTH'(1) : mask_q;
      lfsr_en_q <= cfg_wdata[3];
    end else if (inj_stay) begin
      lfsr_q    <= lfsr_nxt;
    end
  end
`endif

  // ---------------- state register ----------------
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      fsel_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      fsel_q  <= fsel_d;
      if (arm_take) begin
        mode_q <= cfg_wdata[1];
      end
    end
  end

  // ---------------- config registers ----------------
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      mask_q  <= '0;
      value_q <= '0;
      delay_q <= '0;
      dur_q   <= '0;
    end else if (cfg_we && !busy) begin
      case (cfg_addr)
        A_MASK:     mask_q  <= cfg_wdata[WIDTH-1:0];
        A_VALUE:    value_q <= cfg_wdata[WIDTH-1:0];
        A_DELAY:    delay_q <= cfg_wdata[CNT_W-1:0];
        A_DURATION: dur_q   <= cfg_wdata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    if (abort_cmd) begin
      // Abort beats any simultaneous trigger or counter expiry.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm_cmd) begin
            state_d = cfg_wdata[2] ? S_WAIT_TRIG : S_DELAY;
          end
        end
        S_WAIT_TRIG: begin
          if (trig_in) begin
            state_d = S_DELAY;
          end
        end
        S_DELAY: begin
          if (cnt_q == '0) begin
            state_d = S_INJECT;
          end
        end
        S_INJECT: begin
          // A count of zero means a permanent fault: only abort leaves.
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Shared delay/duration counter: loads on entry, then saturating decrement.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d == S_DELAY) && (state_q != S_DELAY)) begin
      cnt_d = delay_q;
    end else if ((state_d == S_INJECT) && (state_q != S_INJECT)) begin
      cnt_d = dur_q;
    end else if (((state_q == S_DELAY) || (state_q == S_INJECT)) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // ---------------- output logic ----------------
  always_comb begin
    sel_d  = 1'b0;
    fsel_d = '0;
    busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    done   = (state_q == S_DONE);
    if (state_d == S_INJECT) begin
      sel_d  = 1'b1;
`ifdef FAULT_INJ_LFSR_EN
      if (lfsr_en_q) begin
        fsel_d = (state_q == S_INJECT) ? lfsr_nxt : lfsr_q;
      end else begin
        fsel_d = mask_q;
      end
`else
      fsel_d = mask_q;
`endif
    end
  end

  assign sel_out  = sel_q;
  assign fsel_out = fsel_q;
  // Bit-flip data is live so flipped bits follow the datapath; fsel_out gates its effect.
  assign fdata_out = mode_q ? ~cdata_in : value_q;

endmodule

// File: tb/tb_fault_injection_ctrl.sv
// Purpose : directed self-checking bench for fault_injection_ctrl.
// Latency : inputs driven right after an active edge, outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_fault_injection_ctrl;

  localparam int WIDTH = 18;

  logic             clk;
  logic             rst;
  logic             cfg_we;
  logic [2:0]       cfg_addr;
  logic [31:0]      cfg_wdata;
  logic             trig_in;
  logic [WIDTH-1:0] cdata_in;
  logic [WIDTH-1:0] fdata_out;
  logic [WIDTH-1:0] fsel_out;
  logic             sel_out;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  fault_injection_ctrl #(.WIDTH(WIDTH), .CNT_W(32)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .trig_in        (trig_in),
    .cdata_in       (cdata_in),
    .fdata_out      (fdata_out),
    .fsel_out       (fsel_out),
    .sel_out        (sel_out),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Drives one config write that lands on the next rising edge; returns just after it.
  task automatic cfg_write(input logic [2:0] addr, input logic [31:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    @(posedge clk);
    #1;
    cfg_we    = 1'b0;
    cfg_addr  = 3'd0;
    cfg_wdata = 32'd0;
  endtask

  // {sel, busy, done}
  function automatic logic [2:0] st();
    return {sel_out, busy, done};
  endfunction

  initial begin
    int sel_cnt;
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = 3'd0;
    cfg_wdata = 32'd0;
    trig_in   = 1'b0;
    cdata_in  = '0;

    // ---------------- reset and idle ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_status", {29'd0, st()}, 32'd0);
    chk("rst_fsel", fsel_out, 32'd0);
    chk("rst_fdata", fdata_out, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_status_fsel", {11'd0, st(), fsel_out}, 32'd0);
    end

    // ---------------- stuck-at, DELAY=3, DURATION=2 ----------------
    cfg_write(3'd1, 32'h00001);
    cfg_write(3'd2, 32'h00001);
    cfg_write(3'd3, 32'd3);
    cfg_write(3'd4, 32'd2);
    cfg_write(3'd0, 32'h1);           // arm edge = E0
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      // sel high between E4..E6, done from E6 on
      chk("sa_sel", {31'd0, sel_out}, (k == 4 || k == 5) ? 32'd1 : 32'd0);
      chk("sa_busy_done", {30'd0, busy, done}, (k < 6) ? 32'd2 : 32'd1);
      if (k == 4) begin
        chk("sa_fsel", fsel_out, 32'h00001);
        chk("sa_fdata", fdata_out, 32'h00001);
      end
    end

    // ---------------- bit-flip with external trigger ----------------
    cfg_write(3'd1, 32'h3FFFF);
    cfg_write(3'd3, 32'd0);
    cfg_write(3'd4, 32'd1);
    cdata_in = 18'h2AAAA;
    trig_in  = 1'b1;                  // coincides with arm: must be ignored
    cfg_write(3'd0, 32'h7);           // arm, bit-flip, trig_src=1
    trig_in  = 1'b0;
    sel_cnt  = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sel_out) sel_cnt++;
      if (k < 5) chk("bf_wait", {29'd0, st()}, 32'b010);
      if (k == 4) trig_in = 1'b1;     // sampled at E5
      if (k == 5) begin
        trig_in = 1'b0;
        chk("bf_delay", {29'd0, st()}, 32'b010);
      end
      if (k == 6) begin
        chk("bf_sel", {31'd0, sel_out}, 32'd1);
        chk("bf_fdata", fdata_out, 32'h15555);
        chk("bf_fsel", fsel_out, 32'h3FFFF);
        cdata_in = 18'h00000;
        #1;
        chk("bf_fdata_live", fdata_out, 32'h3FFFF);
        cdata_in = 18'h2AAAA;
      end
      if (k == 7) chk("bf_done", {29'd0, st()}, 32'b001);
    end
    chk("bf_sel_cycles", sel_cnt, 32'd1);

    // ---------------- permanent injection then abort ----------------
    cfg_write(3'd4, 32'd0);
    cfg_write(3'd2, 32'h12345);
    cfg_write(3'd0, 32'h1);           // stuck-at, DELAY=0 -> INJECT at E1
    sel_cnt = 0;
    @(negedge clk);
    chk("perm_pre", {31'd0, sel_out}, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (sel_out) sel_cnt++;
    end
    chk("perm_sel_cycles", sel_cnt, 32'd20);
    chk("perm_fdata", fdata_out, 32'h12345);
    cfg_write(3'd0, 32'h0);           // abort
    chk("perm_abort_status", {29'd0, st()}, 32'd0);
    chk("perm_abort_fsel", fsel_out, 32'd0);

    // ---------------- dropped write, abort vs expiry ----------------
    cfg_write(3'd1, 32'h00003);
    cfg_write(3'd3, 32'd5);
    cfg_write(3'd4, 32'd2);
    cfg_write(3'd0, 32'h1);           // E0: DELAY loads 5
    cfg_write(3'd1, 32'h0000F);       // E1: busy, dropped
    for (int k = 1; k <= 6; k++) @(negedge clk);
    chk("drop_sel", {31'd0, sel_out}, 32'd1);
    chk("drop_fsel", fsel_out, 32'h00003);
    @(negedge clk);                   // second INJECT cycle; expiry due at next edge
    cfg_write(3'd0, 32'h0);           // abort on the expiry edge
    @(negedge clk);
    chk("abort_expiry", {29'd0, st()}, 32'd0);

    // ---------------- reset in the middle of INJECT ----------------
    cfg_write(3'd3, 32'd0);
    cfg_write(3'd4, 32'd0);
    cfg_write(3'd0, 32'h1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_inj_sel", {31'd0, sel_out}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_status", {29'd0, st()}, 32'd0);
    chk("mid_rst_fdata", fdata_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef FAULT_INJ_LFSR_EN
    // ---------------- LFSR select pattern ----------------
    cfg_write(3'd1, 32'h00001);
    cfg_write(3'd3, 32'd0);
    cfg_write(3'd4, 32'd3);
    cfg_write(3'd0, 32'h9);           // arm + lfsr_en
    @(negedge clk);
    @(negedge clk);
    chk("lfsr_p0", fsel_out, 32'h00001);
    @(negedge clk);
    chk("lfsr_p1", fsel_out, 32'h00002);
    @(negedge clk);
    chk("lfsr_p2", fsel_out, 32'h00004);
    @(negedge clk);
    chk("lfsr_done", {29'd0, st()}, 32'b001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
